// File: rtl/biquad_capture_pkg.sv
// Shared types and helpers for the biquad capture gate / filter-reset sequencer.
package biquad_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StGate,
    StPost,
    StFrst
  } state_t;

  localparam int unsigned DefPreLen  = 32;
  localparam int unsigned DefGateLen = 64;
  localparam int unsigned DefPostLen = 64;
  localparam int unsigned DefRstLen  = 32;

  // LSB of channel c within a packed multi-channel sample bus.
  function automatic int unsigned chan_lsb(input int unsigned c, input int unsigned nsamp,
                                           input int unsigned nbits);
    return c * nsamp * nbits;
  endfunction

endpackage

// File: rtl/biquad_capture_sequencer_if.sv
// Control, configuration and data signals of the capture sequencer.
interface biquad_capture_sequencer_if #(
  parameter int unsigned NCHAN   = 2,
  parameter int unsigned NSAMP   = 8,
  parameter int unsigned NBITS   = 12,
  parameter int unsigned CNTBITS = 16
);
  localparam int unsigned DW = NCHAN * NSAMP * NBITS;

  logic               capture_i;
  logic               abort_i;
  logic               repeat_i;
  logic [CNTBITS-1:0] pre_len_i;
  logic [CNTBITS-1:0] gate_len_i;
  logic [CNTBITS-1:0] post_len_i;
  logic [CNTBITS-1:0] rst_len_i;
  logic [NCHAN-1:0]   chan_mask_i;
  logic [DW-1:0]      dat_i;
  logic [DW-1:0]      dat_o;
  logic               gate_o;
  logic               filt_rst_o;
  logic               busy_o;
  logic               done_o;
  logic [7:0]         missed_o;

  modport master (
    output capture_i, abort_i, repeat_i, pre_len_i, gate_len_i, post_len_i, rst_len_i,
           chan_mask_i, dat_i,
    input  dat_o, gate_o, filt_rst_o, busy_o, done_o, missed_o
  );

  modport slave (
    input  capture_i, abort_i, repeat_i, pre_len_i, gate_len_i, post_len_i, rst_len_i,
           chan_mask_i, dat_i,
    output dat_o, gate_o, filt_rst_o, busy_o, done_o, missed_o
  );

endinterface

// File: rtl/capture_phase_counter.sv
// Down-counter timing one sequencer phase; a phase of length len lasts max(len,1) cycles.
module capture_phase_counter #(
  parameter int unsigned CNTBITS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [CNTBITS-1:0] len_i,
  output logic               last_o
);

  logic [CNTBITS-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (len_i == '0) ? '0 : len_i - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/biquad_capture_sequencer.sv
// Capture gate and filter-reset sequencer: IDLE -> PRE -> GATE -> POST -> FRST, registered outputs.
module biquad_capture_sequencer
  import biquad_capture_pkg::*;
#(
  parameter int unsigned NCHAN   = 2,
  parameter int unsigned NSAMP   = 8,
  parameter int unsigned NBITS   = 12,
  parameter int unsigned CNTBITS = 16
) (
  input logic                      clk_i,
  input logic                      rst_i,
  biquad_capture_sequencer_if.slave bus
);

  localparam int unsigned CW = NSAMP * NBITS;

  state_t             state_q, state_d;
  logic               cap_q;
  logic               cap_edge;
  logic               abort_q, abort_d;
  logic [CNTBITS-1:0] gate_len_q, post_len_q, rst_len_q;
  logic [NCHAN-1:0]   mask_q;
  logic               snap;
  logic               load;
  logic [CNTBITS-1:0] load_len;
  logic               last;
  logic               gate_q, frst_q, frst_end_q, done_q, busy_q;
  logic [7:0]         missed_q;
  logic [CW-1:0]      dat_q [NCHAN];

  assign cap_edge = bus.capture_i & ~cap_q;

  capture_phase_counter #(
    .CNTBITS (CNTBITS)
  ) u_phase_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .len_i  (load_len),
    .last_o (last)
  );

  // The trigger and repeat paths load the live pre_len_i since the snapshot lands on the same edge.
  always_comb begin
    state_d  = state_q;
    abort_d  = abort_q;
    snap     = 1'b0;
    load     = 1'b0;
    load_len = bus.pre_len_i;
    unique case (state_q)
      StIdle: begin
        if (cap_edge) begin
          state_d = StPre;
          abort_d = 1'b0;
          snap    = 1'b1;
          load    = 1'b1;
        end
      end
      StPre, StGate, StPost: begin
        if (bus.abort_i) begin
          state_d  = StFrst;
          abort_d  = 1'b1;
          load     = 1'b1;
          load_len = rst_len_q;
        end else if (last) begin
          load = 1'b1;
          if (state_q == StPre) begin
            state_d  = StGate;
            load_len = gate_len_q;
          end else if (state_q == StGate) begin
            state_d  = StPost;
            load_len = post_len_q;
          end else begin
            state_d  = StFrst;
            load_len = rst_len_q;
          end
        end
      end
      StFrst: begin
        if (last) begin
          if (bus.repeat_i && !abort_q) begin
            state_d = StPre;
            snap    = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cap_q      <= 1'b1;
      abort_q    <= 1'b0;
      gate_len_q <= '0;
      post_len_q <= '0;
      rst_len_q  <= '0;
      mask_q     <= '0;
      gate_q     <= 1'b0;
      frst_q     <= 1'b0;
      frst_end_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      missed_q   <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= bus.capture_i;
      abort_q    <= abort_d;
      if (snap) begin
        gate_len_q <= bus.gate_len_i;
        post_len_q <= bus.post_len_i;
        rst_len_q  <= bus.rst_len_i;
        mask_q     <= bus.chan_mask_i;
      end
      gate_q     <= (state_q == StGate);
      frst_q     <= (state_q == StFrst);
      frst_end_q <= (state_q == StFrst) && last;
      done_q     <= frst_end_q;
      busy_q     <= (state_q != StIdle);
      if (cap_edge && (state_q != StIdle) && (missed_q != 8'hFF)) begin
        missed_q <= missed_q + 8'd1;
      end
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    localparam int unsigned Lsb = chan_lsb(int'(c), NSAMP, NBITS);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        dat_q[c] <= '0;
      end else if ((state_q == StGate) && mask_q[c]) begin
        dat_q[c] <= bus.dat_i[Lsb +: CW];
      end else begin
        dat_q[c] <= '0;
      end
    end

    assign bus.dat_o[Lsb +: CW] = dat_q[c];
  end

  assign bus.gate_o     = gate_q;
  assign bus.filt_rst_o = frst_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.missed_o   = missed_q;

endmodule
